// File: rtl/loader_pkg.sv
// Shared constants and state encodings for the UART ROM loader.
package loader_pkg;

   localparam logic [7:0] SYNC_BYTE     = 8'hA5;
   localparam int         TIMEOUT_BYTES = 16;

   typedef enum logic [1:0] {
      R_IDLE,
      R_START,
      R_DATA,
      R_STOP
   } rx_state_t;

   typedef enum logic [2:0] {
      P_SYNC,
      P_LEN0,
      P_LEN1,
      P_WORD,
      P_CSUM,
      P_DONE
   } p_state_t;

endpackage

// File: rtl/uart_rx_byte.sv
// 8N1 UART receiver: 2-flop synchroniser, mid-bit sampling, one-cycle
// byte_vld / frm_err pulses at the stop-bit sample point.
module uart_rx_byte
   import loader_pkg::*;
#(
   parameter int DIV = 434
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       i_rx,
   output logic       o_byte_vld,
   output logic [7:0] o_byte_data,
   output logic       o_frm_err
);

   localparam logic [15:0] C_FULL = 16'(DIV - 1);
   localparam logic [15:0] C_HALF = 16'(DIV / 2 - 1);

   rx_state_t   r_state;
   rx_state_t   w_nxt;
   logic [1:0]  r_sync;
   logic        r_prev;
   logic [15:0] r_cnt;
   logic [2:0]  r_bit;
   logic [7:0]  r_shift;
   logic        w_rx;

   assign w_rx        = r_sync[1];
   assign o_byte_data = r_shift;

   always_comb begin
      w_nxt      = r_state;
      o_byte_vld = 1'b0;
      o_frm_err  = 1'b0;
      case (r_state)
         R_IDLE:  if (r_prev && !w_rx) w_nxt = R_START;
         R_START: if (r_cnt == C_HALF) w_nxt = w_rx ? R_IDLE : R_DATA;
         R_DATA:  if (r_cnt == C_FULL && r_bit == 3'd7) w_nxt = R_STOP;
         R_STOP: begin
            if (r_cnt == C_FULL) begin
               w_nxt      = R_IDLE;
               o_byte_vld = w_rx;
               o_frm_err  = !w_rx;
            end
         end
         default: w_nxt = R_IDLE;
      endcase
   end

   // Sync flops reset to the idle-high line level so reset release is not a start bit.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state <= R_IDLE;
         r_sync  <= 2'b11;
         r_prev  <= 1'b1;
         r_cnt   <= '0;
         r_bit   <= '0;
         r_shift <= '0;
      end else begin
         r_state <= w_nxt;
         r_sync  <= {r_sync[0], i_rx};
         r_prev  <= w_rx;
         if (r_state == R_IDLE || w_nxt != r_state || r_cnt == C_FULL)
            r_cnt <= '0;
         else
            r_cnt <= r_cnt + 16'd1;
         if (r_state == R_START) begin
            r_bit <= '0;
         end else if (r_state == R_DATA && r_cnt == C_FULL) begin
            r_shift <= {w_rx, r_shift[7:1]};
            r_bit   <= r_bit + 3'd1;
         end
      end
   end

endmodule

// File: rtl/uart_rom_loader.sv
// UART program-image loader driving the instruction ROM write port.
// Define LOADER_CHECKSUM_EN to require a trailing XOR checksum byte.
module uart_rom_loader
   import loader_pkg::*;
#(
   parameter int          CLK_FREQ  = 50_000_000,
   parameter int          BAUD      = 115200,
   parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
   parameter int          MAX_WORDS = 4096
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        uart_debug_pin,
   output logic        mem_we_o,
   output logic [31:0] mem_addr_o,
   output logic [31:0] mem_data_o,
   output logic        halt_req_o,
   output logic        load_done_o,
   output logic        load_err_o
);

   localparam int          DIV    = CLK_FREQ / BAUD;
   localparam logic [31:0] C_TMO  = 32'(TIMEOUT_BYTES * 10 * DIV - 1);
   localparam logic [16:0] C_MAXW = 17'(MAX_WORDS);

   p_state_t    r_state;
   p_state_t    w_nxt;
   logic        w_vld;
   logic [7:0]  w_byte;
   logic        w_frm_err;
   logic [15:0] r_len;
   logic [15:0] r_idx;
   logic [1:0]  r_bcnt;
   logic [23:0] r_word;
   logic [31:0] r_tmo;
   logic [15:0] w_len;
   logic        w_in_load;
   logic        w_tmo;
   logic        w_start;
   logic        w_fail;
   logic        w_finish;
   logic        w_wr;
`ifdef LOADER_CHECKSUM_EN
   logic [7:0]  r_csum;
`endif

   uart_rx_byte #(.DIV(DIV)) u_rx (
      .clk         (clk),
      .rst         (rst),
      .i_rx        (uart_debug_pin),
      .o_byte_vld  (w_vld),
      .o_byte_data (w_byte),
      .o_frm_err   (w_frm_err)
   );

   assign w_len     = {w_byte, r_len[7:0]};
   assign w_in_load = (r_state != P_SYNC) && (r_state != P_DONE);
   assign w_tmo     = w_in_load && !w_vld && (r_tmo == C_TMO);

   always_comb begin
      w_nxt    = r_state;
      w_start  = 1'b0;
      w_fail   = 1'b0;
      w_finish = 1'b0;
      w_wr     = 1'b0;
      case (r_state)
         P_SYNC: begin
            if (w_vld && w_byte == SYNC_BYTE) begin
               w_start = 1'b1;
               w_nxt   = P_LEN0;
            end
         end
         P_LEN0: if (w_vld) w_nxt = P_LEN1;
         P_LEN1: begin
            if (w_vld) begin
               if (w_len == 16'd0 || {1'b0, w_len} > C_MAXW) w_fail = 1'b1;
               else w_nxt = P_WORD;
            end
         end
         P_WORD: begin
            if (w_vld && r_bcnt == 2'd3) begin
               w_wr = 1'b1;
`ifdef LOADER_CHECKSUM_EN
               if (r_idx == r_len - 16'd1) w_nxt = P_CSUM;
`else
               if (r_idx == r_len - 16'd1) w_nxt = P_DONE;
`endif
            end
         end
`ifdef LOADER_CHECKSUM_EN
         P_CSUM: begin
            if (w_vld) begin
               if (w_byte == r_csum) w_finish = 1'b1;
               else w_fail = 1'b1;
            end
         end
`endif
         // P_DONE delays done by one cycle so it follows the final write.
         P_DONE:  w_finish = 1'b1;
         default: w_nxt = P_SYNC;
      endcase
      if (w_in_load && (w_frm_err || w_tmo)) w_fail = 1'b1;
      if (w_fail || w_finish) w_nxt = P_SYNC;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state     <= P_SYNC;
         r_len       <= '0;
         r_idx       <= '0;
         r_bcnt      <= '0;
         r_word      <= '0;
         r_tmo       <= '0;
         mem_we_o    <= 1'b0;
         mem_addr_o  <= '0;
         mem_data_o  <= '0;
         halt_req_o  <= 1'b0;
         load_done_o <= 1'b0;
         load_err_o  <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
         r_csum      <= '0;
`endif
      end else begin
         r_state  <= w_nxt;
         mem_we_o <= w_wr;
         r_tmo    <= (w_vld || !w_in_load) ? 32'd0 : r_tmo + 32'd1;
         if (w_start) begin
            halt_req_o  <= 1'b1;
            load_done_o <= 1'b0;
            load_err_o  <= 1'b0;
            r_idx       <= '0;
            r_bcnt      <= '0;
`ifdef LOADER_CHECKSUM_EN
            r_csum      <= '0;
`endif
         end
         if (w_vld && (r_state == P_LEN0 || r_state == P_LEN1 || r_state == P_WORD)) begin
`ifdef LOADER_CHECKSUM_EN
            r_csum <= r_csum ^ w_byte;
`endif
            if (r_state == P_LEN0) r_len[7:0]  <= w_byte;
            if (r_state == P_LEN1) r_len[15:8] <= w_byte;
         end
         if (w_vld && r_state == P_WORD) begin
            r_word <= {w_byte, r_word[23:8]};
            r_bcnt <= r_bcnt + 2'd1;
         end
         if (w_wr) begin
            mem_data_o <= {w_byte, r_word};
            mem_addr_o <= BASE_ADDR + {14'd0, r_idx, 2'b00};
            r_idx      <= r_idx + 16'd1;
         end
         if (w_fail) begin
            load_err_o <= 1'b1;
            halt_req_o <= 1'b0;
         end
         if (w_finish) begin
            load_done_o <= 1'b1;
            halt_req_o  <= 1'b0;
         end
      end
   end

endmodule

// File: doc/uart_rom_loader.md
# uart_rom_loader

UART download engine that sits directly upstream of the SoC instruction ROM. It receives a framed program image on `uart_debug_pin` and writes it word-by-word into ROM through a simple write port. While a load is in progress it holds the core in halt. It is the hardware path that replaces the simulation-only `$readmemh` preload of ROM contents.

## Interface
- `CLK_FREQ`, 50_000_000, system clock frequency in Hz.
- `BAUD`, 115200, UART bit rate. Divisor `DIV = CLK_FREQ/BAUD`, which is 434 at the defaults.
- `BASE_ADDR`, 32'h0000_0000, ROM byte address of word 0.
- `MAX_WORDS`, 4096, largest accepted word count.
- `clk`  in  1  system clock.
- `rst`  in  1  reset, asynchronous assert, active-low.
- `uart_debug_pin`  in  1  UART RX line, 8N1, idles high.
- `mem_we_o`  out  1  ROM write strobe, one-cycle pulse.
- `mem_addr_o`  out  32  ROM byte address.
- `mem_data_o`  out  32  ROM write data.
- `halt_req_o`  out  1  core hold request.
- `load_done_o`  out  1  sticky flag: the last load completed.
- `load_err_o`  out  1  sticky flag: the last load failed.

## Operation
- **Reset:** all outputs are 0, and both FSMs are in their idle states.
- **RX input:** `uart_debug_pin` passes through a 2-flop synchroniser before any use.
- **RX FSM**
  - R_IDLE: a falling edge moves to R_START.
  - R_START: wait DIV/2 cycles. If the line is still low, go to R_DATA; otherwise return to R_IDLE.
  - R_DATA: sample 8 bits LSB-first, every DIV cycles.
  - R_STOP: sample the stop bit. High gives a 1-cycle `byte_vld`; low gives a 1-cycle `frm_err`. Either way return to R_IDLE.
- **Protocol FSM**
  - P_SYNC: discard every byte until SYNC_BYTE 0xA5 is received. On 0xA5, clear done/err, set `halt_req_o`, and go to P_LEN0.
  - P_LEN0 / P_LEN1: receive the 16-bit little-endian word count. A count of 0 or greater than MAX_WORDS is an error.
  - P_WORD: assemble 4 bytes little-endian per word. After byte 4, issue a write to `BASE_ADDR + 4*index` and increment index. After the last word, go to P_CSUM (macro defined) or finish.
  - Finish: set `load_done_o`, clear `halt_req_o`, return to P_SYNC.
- **Error**
  - Triggers: `frm_err` outside P_SYNC, a bad count, a checksum mismatch, or inter-byte idle exceeding 16 byte-times (160*DIV cycles) outside P_SYNC.
  - Response: set `load_err_o`, clear `halt_req_o`, return to P_SYNC.
  - A partial word is never written. Words already written stay written.
- **Framing errors in P_SYNC** are ignored.
- A 0xA5 received in any state other than P_SYNC is treated as data.
- `mem_addr_o` and `mem_data_o` hold their values between writes.

## Timing
- `byte_vld` fires 2 sync cycles plus about 9.5 bit-times after the start-bit falling edge.
- `mem_we_o` is high for exactly one cycle, in the cycle after `byte_vld` of a word's 4th byte. `mem_addr_o` and `mem_data_o` are valid in that same cycle.
- `load_done_o` rises the cycle after the final write (no checksum), or the cycle after the checksum `byte_vld`.
- `halt_req_o` rises the cycle after the 0xA5 `byte_vld`, and falls in the same cycle that done or err rises.
- Reset asserted mid-load aborts the load immediately. All outputs go to 0, including `halt_req_o`.

## Configuration
- Macro: `LOADER_CHECKSUM_EN`.
- **Defined:** a trailing checksum byte follows the last word. It equals the XOR of the two length bytes and all data bytes. A mismatch sets `load_err_o` and `load_done_o` stays 0.
- **Undefined:** there is no checksum byte, and done follows the last write.

## Structure
- Package `loader_pkg` holds:
  - SYNC_BYTE = 8'hA5;
  - TIMEOUT_BYTES = 16;
  - the RX state enum and the protocol state enum.
- Sub-module `uart_rx_byte` (synchroniser plus RX FSM) outputs `byte_vld`, `byte_data[7:0]` and `frm_err`. The loader top level holds the protocol FSM, word assembly, index counter and timeout counter.

## Test plan
- **Reset:** hold `rst`=0 while the line toggles → every output stays 0, no `mem_we_o` pulses.
- **Basic load:** send A5 02 00 78 56 34 12 EF BE AD DE (macro off) → writes 0x12345678@0x0 and 0xDEADBEEF@0x4; `load_done_o`=1; `halt_req_o` 1→0.
- **Leading garbage:** send 00 FF 3C, then the basic-load frame → identical writes, no error.
- **Zero count:** send A5 00 00 → `load_err_o`=1, no writes, `halt_req_o`=0.
- **Stop-bit error:** drive the stop bit low on data byte 3 → `load_err_o`=1, no write, halt released. Then reset mid-word → all outputs 0.
- **Checksum (macro on):** basic-load frame plus checksum 28 → done=1. Same frame plus checksum 29 → err=1, done=0, both words still written.
